// File: rtl/serial_word_comparator.sv
// serial_word_comparator
//
// Multi-cycle unsigned magnitude comparator. The two operands are walked
// MSB-first in 2-bit slices, one slice per clock. The first slice that
// differs decides the result, and that decision is then held (sticky) for
// the rest of the operation. This avoids a wide combinational compare cone.
//
// Build option:
//   SERIAL_CMP_EARLY_EXIT_EN  defined   -> finish on the first differing slice
//                                          (latency 1..N cycles)
//                             undefined -> always walk all N slices
//                                          (latency fixed at N cycles)
//   The result values are the same in both builds. Only busy/done timing differs.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    compare request, sampled only while idle
//   a, b     WIDTH-bit unsigned operands, captured when start is accepted
//   busy     high while the comparison is running
//   done     one-cycle pulse when the result is registered
//   greater  a > b  (held until the next accepted start)
//   equal    a == b (held until the next accepted start)
//   less     a < b  (held until the next accepted start)

module serial_word_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             equal,
  output logic             less
);

  localparam int N    = WIDTH / 2;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    DEC_NONE = 2'b00,
    DEC_GT   = 2'b01,
    DEC_LT   = 2'b10
  } dec_t;

  state_t            state;
  dec_t              dec;
  dec_t              dec_next;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;

  logic [1:0]        sa;
  logic [1:0]        sb;
  logic              slice_gt;
  logic              slice_lt;
  logic              finish;

  // Slice selection and the 2-bit greater/less equations for the current slice.
  // NOTE: every signal written in this always_comb is given a default first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sa       = a_q[{idx, 1'b0} +: 2];
    sb       = b_q[{idx, 1'b0} +: 2];
    slice_gt = (sa[1] & ~sb[1]) | (~(sa[1] ^ sb[1]) & sa[0] & ~sb[0]);
    slice_lt = (~sa[1] & sb[1]) | (~(sa[1] ^ sb[1]) & ~sa[0] & sb[0]);

    // The first difference wins; later slices never override it.
    dec_next = dec;
    if (dec == DEC_NONE) begin
      if (slice_gt)      dec_next = DEC_GT;
      else if (slice_lt) dec_next = DEC_LT;
    end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish = (idx == '0) || slice_gt || slice_lt;
`else
    finish = (idx == '0);
`endif
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      greater <= 1'b0;
      equal   <= 1'b0;
      less    <= 1'b0;
      idx     <= '0;
      dec     <= DEC_NONE;
      // NOTE: a_q/b_q are pure datapath copies. They are always loaded before
      // they are read, so they are left out of reset.
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx     <= IDXW'(N - 1);
            dec     <= DEC_NONE;
            greater <= 1'b0;
            equal   <= 1'b0;
            less    <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end

        ST_RUN: begin
          dec <= dec_next;
          if (finish) begin
            greater <= (dec_next == DEC_GT);
            less    <= (dec_next == DEC_LT);
            equal   <= (dec_next == DEC_NONE);
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_comparator.sv
// tb_serial_word_comparator
//
// Randomised plus directed bench for serial_word_comparator (WIDTH=8).
// A reference model works out the result of each accepted compare with
// plain integer comparison. It works out the latency from the position of
// the first differing slice, then pushes the expectation into a scoreboard
// queue. A monitor running on the falling edge pops an entry on every done
// pulse and checks the result and its timing. On every cycle it also checks
// busy, done and the held flags.

module tb_serial_word_comparator;

  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, greater, equal, less;

  serial_word_comparator #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .greater(greater),
    .equal  (equal),
    .less   (less)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;   // edge after which done must be visible
    logic [2:0] res;   // {greater, equal, less}
  } exp_t;

  exp_t       sbq[$];
  int         errors = 0;
  int         checks = 0;
  int         edge_n = 0;
  bit         armed  = 1'b0;

  // Model view of the comparator.
  bit         pend = 1'b0;
  int         pend_due = 0;
  logic [2:0] pend_res = 3'b000;
  logic [2:0] shown = 3'b000;
  int         done_edge = -1;

  function automatic logic [2:0] ref_result(input int unsigned x, input int unsigned y);
    if (x > y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  function automatic int ref_latency(input int unsigned x, input int unsigned y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int k = 0; k < N; k++) begin
      int sh = 2 * (N - 1 - k);
      if (((x >> sh) & 3) != ((y >> sh) & 3)) return k + 1;
    end
    return N;
`else
    return N;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: updated on each rising edge from the bench-driven inputs.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      armed = 1'b1;
      if (rst) begin
        sbq.delete();
        pend      = 1'b0;
        shown     = 3'b000;
        done_edge = -1;
      end else if (!pend && start) begin
        int lat;
        lat      = ref_latency(int'(a), int'(b));
        pend     = 1'b1;
        pend_due = edge_n + lat;
        pend_res = ref_result(int'(a), int'(b));
        shown    = 3'b000;
        sbq.push_back('{due: edge_n + lat, res: pend_res});
      end else if (pend && edge_n == pend_due) begin
        pend      = 1'b0;
        shown     = pend_res;
        done_edge = edge_n;
      end
    end
  end

  // Monitor: samples DUT outputs half a cycle after each active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        if (done) begin
          if (sbq.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            exp_t x;
            x = sbq.pop_front();
            check("done_edge", edge_n, x.due);
            check("result", 32'({greater, equal, less}), 32'(x.res));
          end
        end
        while (sbq.size() > 0 && sbq[0].due < edge_n) begin
          exp_t x;
          x = sbq.pop_front();
          check("done_missing", 32'(done), 32'd1);
        end
        check("status", 32'({busy, done, greater, equal, less}),
              32'({pend, (done_edge == edge_n), shown}));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && pend; i++) tick();
    tick();
  endtask

  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Directed cases: equal operands, MSB-slice difference, LSB-slice
    // difference, sticky top decision, and the extreme operand values.
    run_op(8'hA5, 8'hA5);
    run_op(8'hC0, 8'h40);
    run_op(8'h12, 8'h13);
    run_op(8'h80, 8'h7F);
    run_op(8'h00, 8'hFF);
    run_op(8'hFF, 8'hFF);

    // A start while busy is ignored, and the operands are not re-sampled.
    a = 8'h01; b = 8'h02; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();

    // Start held high: each done cycle also accepts the next operation.
    a = 8'h05; b = 8'h05; start = 1'b1;
    repeat (16) tick();
    start = 1'b0;
    wait_idle();

    // Reset in the middle of a run, then a normal operation afterwards.
    a = 8'h10; b = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_op(8'h3C, 8'h3D);

    // Random traffic: operands that are fully random or differ in one slice,
    // random start activity, and an occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] va;
      logic [WIDTH-1:0] mask;
      va = WIDTH'($urandom);
      a  = va;
      if ($urandom_range(0, 1) == 0) begin
        b = WIDTH'($urandom);
      end else begin
        mask = WIDTH'($urandom_range(1, 3));
        b    = va ^ (mask << (2 * $urandom_range(0, N - 1)));
      end
      start = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst   = 1'b0;
    start = 1'b0;
    wait_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
